// File: rtl/flash_program_controller_pkg.sv
// Shared definitions for the NOR flash program/erase path: CFI commands,
// status register bit positions and the controller state encodings.
package flash_program_controller_pkg;

  localparam int FLASH_ADDR_W = 23;

  typedef logic [FLASH_ADDR_W-1:0] Flash_addr_t;
  typedef logic [15:0]             Halfword_t;

  localparam Halfword_t CMD_PROGRAM       = 16'h0040;
  localparam Halfword_t CMD_ERASE_SETUP   = 16'h0020;
  localparam Halfword_t CMD_ERASE_CONFIRM = 16'h00D0;
  localparam Halfword_t CMD_READ_STATUS   = 16'h0070;
  localparam Halfword_t CMD_CLEAR_STATUS  = 16'h0050;
  localparam Halfword_t CMD_READ_ARRAY    = 16'h00FF;

  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;
  localparam int SR_VPP_ERR   = 3;
  localparam int SR_LOCKED    = 1;

  typedef enum logic [3:0] {
    IDLE, CMD_SETUP, CMD_CONFIRM, STATUS_CMD, STATUS_READ,
    CHECK, CLEAR_STATUS, READ_ARRAY, DONE
  } fpc_state_e;

  typedef enum logic [2:0] {
    CY_IDLE, CY_SETUP, CY_PULSE, CY_HOLD, CY_RWAIT, CY_RREC
  } bus_cycle_e;

  function automatic logic sr_failed(input logic [7:0] sr);
    return sr[SR_ERASE_ERR] | sr[SR_PROG_ERR] | sr[SR_VPP_ERR] | sr[SR_LOCKED];
  endfunction

endpackage

// File: rtl/flash_program_controller_bus_cycle.sv
// Runs one flash write cycle or status read cycle per start pulse and owns
// the data-bus output enable; done_o marks the final cycle of the operation.
module flash_bus_cycle
  import flash_program_controller_pkg::*;
#(
  parameter int ADDR_W   = 23,
  parameter int WE_PULSE = 4,
  parameter int RD_WAIT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              read_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  Halfword_t         wdata_i,
  input  logic [7:0]        flash_d_i,
  output logic              done_o,
  output logic [7:0]        rdata_o,
  output logic [ADDR_W-1:0] flash_a_o,
  output Halfword_t         flash_d_o,
  output logic              flash_d_oe_o,
  output logic              flash_ce_n_o,
  output logic              flash_oe_n_o,
  output logic              flash_we_n_o
);

  localparam int MAXW  = (WE_PULSE > RD_WAIT) ? WE_PULSE : RD_WAIT;
  localparam int CNT_W = $clog2(MAXW + 1);

  bus_cycle_e        ph_q, ph_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] a_q, a_d;
  Halfword_t         wd_q, wd_d;
  logic [7:0]        rd_q, rd_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q  <= CY_IDLE;
      cnt_q <= '0;
      a_q   <= '0;
      wd_q  <= '0;
      rd_q  <= '0;
    end else begin
      ph_q  <= ph_d;
      cnt_q <= cnt_d;
      a_q   <= a_d;
      wd_q  <= wd_d;
      rd_q  <= rd_d;
    end
  end

  always_comb begin
    ph_d   = ph_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    wd_d   = wd_q;
    rd_d   = rd_q;
    done_o = 1'b0;
    case (ph_q)
      CY_IDLE: if (start_i) begin
        ph_d  = read_i ? CY_RWAIT : CY_SETUP;
        cnt_d = '0;
        a_d   = addr_i;
        wd_d  = wdata_i;
      end
      CY_SETUP: ph_d = CY_PULSE;
      CY_PULSE: begin
        if (cnt_q == CNT_W'(WE_PULSE - 1)) ph_d = CY_HOLD;
        else cnt_d = cnt_q + 1'b1;
      end
      CY_HOLD: begin
        ph_d   = CY_IDLE;
        done_o = 1'b1;
      end
      // Status is captured on the last oe_n-low cycle, then oe_n recovers.
      CY_RWAIT: begin
        if (cnt_q == CNT_W'(RD_WAIT - 1)) begin
          ph_d = CY_RREC;
          rd_d = flash_d_i;
        end else cnt_d = cnt_q + 1'b1;
      end
      CY_RREC: begin
        ph_d   = CY_IDLE;
        done_o = 1'b1;
      end
      default: ph_d = CY_IDLE;
    endcase
  end

  assign rdata_o      = rd_q;
  assign flash_a_o    = a_q;
  assign flash_d_o    = wd_q;
  assign flash_d_oe_o = (ph_q == CY_SETUP) || (ph_q == CY_PULSE) || (ph_q == CY_HOLD);
  assign flash_ce_n_o = (ph_q == CY_IDLE);
  assign flash_we_n_o = (ph_q != CY_PULSE);
  assign flash_oe_n_o = (ph_q != CY_RWAIT);

endmodule

// File: rtl/flash_program_controller.sv
// Program/erase sequencer for 16-bit CFI NOR flash: splits a 32-bit word into
// two halfword programs, polls status, and always finishes in Read Array mode.
module flash_program_controller
  import flash_program_controller_pkg::*;
#(
  parameter int ADDR_W     = 23,
  parameter int WE_PULSE   = 4,
  parameter int RD_WAIT    = 4,
  parameter int POLL_LIMIT = 2_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_data_write,
  input  logic              prog_op,
  input  logic              erase_op,
  output logic              bus_stall,
  output logic              bus_error,
  output logic [ADDR_W-1:0] flash_a,
  inout  wire  [15:0]       flash_d,
  output logic              flash_rp_n,
  output logic              flash_vpen,
  output logic              flash_byte_n,
  output logic              flash_ce_n,
  output logic              flash_oe_n,
  output logic              flash_we_n
);

  fpc_state_e        state_q, state_d;
  logic              erase_q, erase_d;
  logic              half_q, half_d;
  logic              issued_q, issued_d;
  logic              err_q, err_d;
  logic              bus_error_q, bus_error_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       poll_q, poll_d;
  logic [7:0]        sr_q, sr_d;

  logic              cyc_start, cyc_read, cyc_done, bus_state;
  Halfword_t         cyc_wdata, d_out;
  logic [7:0]        cyc_rdata;
  logic              d_oe;
  logic [ADDR_W-1:0] cur_addr;

  // High half lives at addr+2; the sum wraps at the address width.
  assign cur_addr  = addr_q + (half_q ? ADDR_W'(2) : ADDR_W'(0));
  assign bus_state = (state_q == CMD_SETUP) || (state_q == CMD_CONFIRM) ||
                     (state_q == STATUS_CMD) || (state_q == STATUS_READ) ||
                     (state_q == CLEAR_STATUS) || (state_q == READ_ARRAY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      erase_q     <= 1'b0;
      half_q      <= 1'b0;
      issued_q    <= 1'b0;
      err_q       <= 1'b0;
      bus_error_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      poll_q      <= '0;
      sr_q        <= '0;
    end else begin
      state_q     <= state_d;
      erase_q     <= erase_d;
      half_q      <= half_d;
      issued_q    <= issued_d;
      err_q       <= err_d;
      bus_error_q <= bus_error_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      poll_q      <= poll_d;
      sr_q        <= sr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    erase_d     = erase_q;
    half_d      = half_q;
    issued_d    = issued_q;
    err_d       = err_q;
    bus_error_d = bus_error_q;
    addr_d      = addr_q;
    data_d      = data_q;
    poll_d      = poll_q;
    sr_d        = sr_q;
    cyc_read    = 1'b0;
    cyc_wdata   = CMD_READ_ARRAY;

    case (state_q)
      IDLE: if (prog_op || erase_op) begin
        erase_d     = erase_op;
        addr_d      = bus_addr;
        data_d      = bus_data_write;
        half_d      = 1'b0;
        err_d       = 1'b0;
        bus_error_d = 1'b0;
        issued_d    = 1'b0;
        state_d     = CMD_SETUP;
      end
      CMD_SETUP:    cyc_wdata = erase_q ? CMD_ERASE_SETUP : CMD_PROGRAM;
      CMD_CONFIRM:  cyc_wdata = erase_q ? CMD_ERASE_CONFIRM
                                        : (half_q ? data_q[31:16] : data_q[15:0]);
      STATUS_CMD:   cyc_wdata = CMD_READ_STATUS;
      STATUS_READ:  cyc_read  = 1'b1;
      CLEAR_STATUS: cyc_wdata = CMD_CLEAR_STATUS;
      READ_ARRAY:   cyc_wdata = CMD_READ_ARRAY;
      CHECK: begin
        if (sr_q[SR_READY]) begin
          if (sr_failed(sr_q)) begin
            err_d   = 1'b1;
            state_d = CLEAR_STATUS;
          end else if (!erase_q && !half_q) begin
            half_d  = 1'b1;
            state_d = CMD_SETUP;
          end else begin
            state_d = READ_ARRAY;
          end
        end else if (poll_q >= 32'(POLL_LIMIT)) begin
          err_d   = 1'b1;
          state_d = CLEAR_STATUS;
        end else begin
          state_d = STATUS_READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cyc_start = bus_state && !issued_q;
    if (cyc_start) issued_d = 1'b1;

    if (cyc_done) begin
      issued_d = 1'b0;
      case (state_q)
        CMD_SETUP:   state_d = CMD_CONFIRM;
        CMD_CONFIRM: state_d = STATUS_CMD;
        STATUS_CMD: begin
          state_d = STATUS_READ;
          poll_d  = '0;
        end
        STATUS_READ: begin
          state_d = CHECK;
          sr_d    = cyc_rdata;
          poll_d  = (poll_q == '1) ? poll_q : poll_q + 32'd1;
        end
        CLEAR_STATUS: state_d = READ_ARRAY;
        // Result becomes visible in the same cycle the stall drops.
        READ_ARRAY: begin
          state_d     = DONE;
          bus_error_d = err_q;
        end
        default: ;
      endcase
    end
  end

  flash_bus_cycle #(
    .ADDR_W  (ADDR_W),
    .WE_PULSE(WE_PULSE),
    .RD_WAIT (RD_WAIT)
  ) u_cycle (
    .clk         (clk),
    .rst         (rst),
    .start_i     (cyc_start),
    .read_i      (cyc_read),
    .addr_i      (cur_addr),
    .wdata_i     (cyc_wdata),
    .flash_d_i   (flash_d[7:0]),
    .done_o      (cyc_done),
    .rdata_o     (cyc_rdata),
    .flash_a_o   (flash_a),
    .flash_d_o   (d_out),
    .flash_d_oe_o(d_oe),
    .flash_ce_n_o(flash_ce_n),
    .flash_oe_n_o(flash_oe_n),
    .flash_we_n_o(flash_we_n)
  );

  assign flash_d      = d_oe ? d_out : 16'hzzzz;
  assign bus_stall    = (state_q != IDLE) && (state_q != DONE);
  assign bus_error    = bus_error_q;
  assign flash_rp_n   = 1'b1;
  assign flash_vpen   = 1'b1;
  assign flash_byte_n = 1'b1;

endmodule

// File: tb/tb_flash_program_controller.sv
// Directed bench for flash_program_controller with a behavioural CFI flash
// model on the pins; the bench drives a known pattern whenever ce_n is high.
module tb_flash_program_controller;

  localparam int AW = 23, WEP = 4, RDW = 4, PL = 12;
  localparam logic [15:0] PROBE = 16'h5A00;
  localparam int PRE_K = (32'h020000 >> 1) + 5;

  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] bus_addr = '0;
  logic [31:0] bus_data_write = '0;
  logic prog_op = 1'b0, erase_op = 1'b0;
  logic bus_stall, bus_error, flash_rp_n, flash_vpen, flash_byte_n;
  logic flash_ce_n, flash_oe_n, flash_we_n;
  logic [AW-1:0] flash_a;
  wire  [15:0] flash_d;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  flash_program_controller #(.ADDR_W(AW), .WE_PULSE(WEP), .RD_WAIT(RDW), .POLL_LIMIT(PL)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_data_write(bus_data_write),
    .prog_op(prog_op), .erase_op(erase_op), .bus_stall(bus_stall), .bus_error(bus_error),
    .flash_a(flash_a), .flash_d(flash_d), .flash_rp_n(flash_rp_n), .flash_vpen(flash_vpen),
    .flash_byte_n(flash_byte_n), .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
    .flash_we_n(flash_we_n));

  // ---------------- flash model ----------------
  logic mdl_rst = 1'b0;
  int ready_polls = 10;
  bit stuck = 0, inj = 0;
  logic [15:0] mem [int];
  int wn = 0, rc_count = 0, busy = 0;
  logic [AW-1:0] wlog_a [32];
  logic [15:0] wlog_d [32];
  bit exp_data = 0, exp_erase = 0, stat = 0;
  logic [6:0] errb = '0;
  logic [15:0] mdl_drv = 16'hFFFF;

  assign flash_d = (!flash_ce_n && !flash_oe_n) ? mdl_drv : 16'hzzzz;
  assign flash_d = flash_ce_n ? PROBE : 16'hzzzz;

  function automatic logic [15:0] mem_rd(input int k);
    return mem.exists(k) ? mem[k] : 16'hFFFF;
  endfunction

  always @(posedge mdl_rst or posedge flash_we_n or negedge flash_oe_n) begin
    if (mdl_rst) begin
      mem.delete(); mem[PRE_K] = 16'h1234;
      wn = 0; rc_count = 0; busy = 0; exp_data = 0; exp_erase = 0; stat = 0; errb = '0;
      mdl_drv = 16'hFFFF;
    end else if (!flash_oe_n) begin
      rc_count++;
      if (busy > 0) busy--;
      mdl_drv = stat ? {8'h00, (busy == 0) && !stuck, errb} : mem_rd(int'(flash_a >> 1));
    end else if (!flash_ce_n) begin
      if (wn < 32) begin wlog_a[wn] = flash_a; wlog_d[wn] = flash_d; end
      wn++;
      if (exp_data) begin
        exp_data = 0; mem[int'(flash_a >> 1)] = flash_d; busy = ready_polls; stat = 1;
        if (inj) errb = errb | 7'h10;
      end else begin
        case (flash_d[7:0])
          8'h40: exp_data = 1;
          8'h20: exp_erase = 1;
          8'hD0: if (exp_erase) begin
            exp_erase = 0; busy = ready_polls; stat = 1;
            foreach (mem[k]) if ((k >> 16) == int'(flash_a >> 17)) mem[k] = 16'hFFFF;
          end
          8'h70: stat = 1;
          8'h50: errb = '0;
          8'hFF: stat = 0;
          default: ;
        endcase
      end
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic mdl_clear();
    mdl_rst = 1'b1; #1; mdl_rst = 1'b0;
  endtask

  task automatic drive_op(input logic p, input logic e, input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk); prog_op = p; erase_op = e; bus_addr = a; bus_data_write = d;
    @(negedge clk); prog_op = 1'b0; erase_op = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      if (!bus_stall) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus_stall !== 1'b0) begin errors++; $display("FAIL rst_held_stall: got %b expected 0", bus_stall); end
    checks++; if (flash_ce_n !== 1'b1) begin errors++; $display("FAIL rst_held_ce_n: got %b expected 1", flash_ce_n); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus_stall); end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", bus_error); end
    checks++; if (flash_a !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", flash_a); end
    checks++; if (flash_d !== PROBE) begin errors++; $display("FAIL reset_bus_release: got %h expected %h", flash_d, PROBE); end
    checks++; if ({flash_ce_n, flash_oe_n, flash_we_n} !== 3'b111) begin errors++; $display("FAIL reset_ctl: got %b expected 111", {flash_ce_n, flash_oe_n, flash_we_n}); end
    checks++; if ({flash_rp_n, flash_vpen, flash_byte_n} !== 3'b111) begin errors++; $display("FAIL reset_ties: got %b expected 111", {flash_rp_n, flash_vpen, flash_byte_n}); end
  endtask

  task automatic test_program();
    logic [15:0] ed [6] = '{16'h0040, 16'hBEEF, 16'h0070, 16'h0040, 16'hDEAD, 16'h0070};
    logic [AW-1:0] ea [6] = '{23'h100, 23'h100, 23'h100, 23'h102, 23'h102, 23'h102};
    bit ok;
    mdl_clear(); ready_polls = 10;
    drive_op(1'b1, 1'b0, 23'h000100, 32'hDEADBEEF);
    checks++; if (bus_stall !== 1'b1) begin errors++; $display("FAIL prog_stall_rise: got %b expected 1", bus_stall); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL prog_timeout: stall stuck high"); end
    checks++; if (wn !== 7) begin errors++; $display("FAIL prog_wc_count: got %0d expected 7", wn); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wlog_d[i] !== ed[i] || wlog_a[i] !== ea[i]) begin
        errors++; $display("FAIL prog_wc%0d: got %h@%h expected %h@%h", i, wlog_d[i], wlog_a[i], ed[i], ea[i]);
      end
    end
    checks++; if (wlog_d[6] !== 16'h00FF) begin errors++; $display("FAIL prog_read_array: got %h expected 00ff", wlog_d[6]); end
    checks++; if (rc_count !== 20) begin errors++; $display("FAIL prog_polls: got %0d expected 20", rc_count); end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL prog_error: got %b expected 0", bus_error); end
    checks++; if ({mem_rd(32'h81), mem_rd(32'h80)} !== 32'hDEADBEEF) begin errors++; $display("FAIL prog_mem: got %h expected deadbeef", {mem_rd(32'h81), mem_rd(32'h80)}); end
  endtask

  task automatic test_erase();
    logic [15:0] ed [4] = '{16'h0020, 16'h00D0, 16'h0070, 16'h00FF};
    bit ok;
    mdl_clear();
    drive_op(1'b0, 1'b1, 23'h020000, 32'h0);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL erase_timeout: stall stuck high"); end
    checks++; if (wn !== 4) begin errors++; $display("FAIL erase_wc_count: got %0d expected 4", wn); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wlog_d[i] !== ed[i]) begin errors++; $display("FAIL erase_wc%0d: got %h expected %h", i, wlog_d[i], ed[i]); end
    end
    checks++; if (wlog_a[1] !== 23'h020000) begin errors++; $display("FAIL erase_addr: got %h expected 020000", wlog_a[1]); end
    checks++; if (rc_count !== 10) begin errors++; $display("FAIL erase_polls: got %0d expected 10", rc_count); end
    checks++; if (mem_rd(PRE_K) !== 16'hFFFF) begin errors++; $display("FAIL erase_mem: got %h expected ffff", mem_rd(PRE_K)); end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL erase_error: got %b expected 0", bus_error); end
  endtask

  task automatic test_status_error();
    logic [15:0] ed [5] = '{16'h0040, 16'h5678, 16'h0070, 16'h0050, 16'h00FF};
    bit ok;
    mdl_clear(); inj = 1;
    drive_op(1'b1, 1'b0, 23'h000300, 32'h12345678);
    wait_idle(ok);
    inj = 0;
    checks++; if (!ok) begin errors++; $display("FAIL serr_timeout: stall stuck high"); end
    checks++; if (wn !== 5) begin errors++; $display("FAIL serr_wc_count: got %0d expected 5", wn); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (wlog_d[i] !== ed[i]) begin errors++; $display("FAIL serr_wc%0d: got %h expected %h", i, wlog_d[i], ed[i]); end
    end
    checks++; if (rc_count !== 10) begin errors++; $display("FAIL serr_polls: got %0d expected 10", rc_count); end
    checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL serr_error: got %b expected 1", bus_error); end
  endtask

  task automatic test_timeout();
    logic [15:0] ed [5] = '{16'h0020, 16'h00D0, 16'h0070, 16'h0050, 16'h00FF};
    bit ok;
    mdl_clear(); stuck = 1;
    drive_op(1'b0, 1'b1, 23'h040000, 32'h0);
    wait_idle(ok);
    stuck = 0;
    checks++; if (!ok) begin errors++; $display("FAIL tmo_timeout: stall stuck high"); end
    checks++; if (rc_count !== PL) begin errors++; $display("FAIL tmo_polls: got %0d expected %0d", rc_count, PL); end
    checks++; if (wn !== 5) begin errors++; $display("FAIL tmo_wc_count: got %0d expected 5", wn); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (wlog_d[i] !== ed[i]) begin errors++; $display("FAIL tmo_wc%0d: got %h expected %h", i, wlog_d[i], ed[i]); end
    end
    checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL tmo_error: got %b expected 1", bus_error); end
  endtask

  task automatic test_priority();
    logic [15:0] ed [4] = '{16'h0020, 16'h00D0, 16'h0070, 16'h00FF};
    bit ok;
    mdl_clear();
    drive_op(1'b1, 1'b1, 23'h060000, 32'hAAAA5555);
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL prio_error_clear: got %b expected 0", bus_error); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL prio_timeout: stall stuck high"); end
    checks++; if (wn !== 4) begin errors++; $display("FAIL prio_wc_count: got %0d expected 4", wn); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wlog_d[i] !== ed[i]) begin errors++; $display("FAIL prio_wc%0d: got %h expected %h", i, wlog_d[i], ed[i]); end
    end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL prio_error: got %b expected 0", bus_error); end
  endtask

  task automatic test_timing();
    int we_run = 0, oe_run = 0, pulses = 0, reads = 0;
    logic prev_we = 1'b1;
    logic [15:0] prev_d = PROBE;
    bit done = 0;
    mdl_clear(); ready_polls = 3;
    drive_op(1'b1, 1'b0, 23'h000500, 32'h0F0FF0F0);
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      if (!flash_we_n) we_run++;
      else if (we_run != 0) begin
        pulses++; checks++;
        if (we_run != WEP) begin errors++; $display("FAIL we_width: got %0d expected %0d", we_run, WEP); end
        we_run = 0;
      end
      if (!flash_oe_n) begin
        oe_run++; checks++;
        if (flash_d !== mdl_drv) begin errors++; $display("FAIL rc_bus_release: got %h expected %h", flash_d, mdl_drv); end
      end else if (oe_run != 0) begin
        reads++; checks++;
        if (oe_run != RDW) begin errors++; $display("FAIL oe_width: got %0d expected %0d", oe_run, RDW); end
        oe_run = 0;
      end
      if (!flash_we_n || !prev_we) begin
        checks++;
        if (flash_d !== prev_d || flash_ce_n !== 1'b0) begin errors++; $display("FAIL wc_data_stable: got %h ce_n %b expected %h ce_n 0", flash_d, flash_ce_n, prev_d); end
      end
      if (flash_ce_n) begin
        checks++;
        if (flash_d !== PROBE) begin errors++; $display("FAIL idle_bus_release: got %h expected %h", flash_d, PROBE); end
      end
      prev_we = flash_we_n; prev_d = flash_d;
      if (!bus_stall) done = 1;
    end
    ready_polls = 10;
    checks++; if (!done) begin errors++; $display("FAIL timing_timeout: stall stuck high"); end
    checks++; if (pulses !== 7) begin errors++; $display("FAIL timing_pulses: got %0d expected 7", pulses); end
    checks++; if (reads !== 6) begin errors++; $display("FAIL timing_reads: got %0d expected 6", reads); end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    mdl_clear();
    drive_op(1'b1, 1'b0, 23'h000700, 32'hCAFEF00D);
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      if (rc_count >= 3 && !flash_oe_n) hit = 1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach_poll: poll phase not seen"); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b expected 0", bus_stall); end
    checks++; if ({flash_ce_n, flash_oe_n, flash_we_n} !== 3'b111) begin errors++; $display("FAIL rstmid_ctl: got %b expected 111", {flash_ce_n, flash_oe_n, flash_we_n}); end
    checks++; if (flash_a !== '0) begin errors++; $display("FAIL rstmid_addr: got %h expected 0", flash_a); end
    checks++; if (flash_d !== PROBE) begin errors++; $display("FAIL rstmid_bus_release: got %h expected %h", flash_d, PROBE); end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL rstmid_error: got %b expected 0", bus_error); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus_stall !== 1'b0 || flash_ce_n !== 1'b1) begin errors++; $display("FAIL rstmid_stays_idle: got stall %b ce_n %b expected 0 1", bus_stall, flash_ce_n); end
  endtask

  initial begin
    test_reset();
    test_program();
    test_erase();
    test_status_error();
    test_timeout();
    test_priority();
    test_timing();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
